// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, default reset PC and fetch FSM states.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      StBoot,
      StRun
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      StFault
`endif
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection (reset, redirect, +4, hold).
module fetch_pc_reg
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        advance_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q, pc_d;

   // Redirect wins over sequential advance; +4 wraps modulo 2^32.
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = redirect_pc_i;
      end else if (advance_i) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect handling and a registered decode interface.
// Defining FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect FAULT state and fetch_fault output.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_AW  = 12
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_instr,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic [31:0]        out_pc,
   output logic [31:0]        out_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic               fetch_fault
`endif
);

   fetch_state_e state_q, state_d;

   logic [31:0] pc;
   logic [31:0] redirect_tgt;
   logic        pc_redirect;
   logic        out_load;
   logic        out_flush;
   logic        out_valid_q;
   logic [31:0] out_instr_q;
   logic [31:0] out_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic redirect_misaligned;
   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
   assign redirect_tgt        = redirect_pc;
`else
   assign redirect_tgt        = redirect_pc & ~32'h3;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StBoot;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StBoot: state_d = StRun;
         StRun:  state_d = StRun;
`ifdef FETCH_MISALIGN_TRAP_EN
         StFault: if (redirect_valid && !redirect_misaligned) state_d = StRun;
`endif
         default: state_d = StBoot;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      // A misaligned target traps from any state, including re-trapping out of FAULT.
      if (redirect_valid && redirect_misaligned) state_d = StFault;
`endif
   end

   always_comb begin
      pc_redirect = 1'b0;
      out_load    = 1'b0;
      out_flush   = 1'b0;
      case (state_q)
         StBoot: pc_redirect = redirect_valid;
         StRun: begin
            if (redirect_valid) begin
               pc_redirect = 1'b1;
               out_flush   = 1'b1;
            end else if (!out_valid_q || out_ready) begin
               out_load = 1'b1;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         StFault: pc_redirect = redirect_valid;
`endif
         default: ;
      endcase
   end

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i         (clk),
      .rst_i         (rst),
      .redirect_i    (pc_redirect),
      .redirect_pc_i (redirect_tgt),
      .advance_i     (out_load),
      .pc_o          (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_instr_q <= NOP_INSTR;
         out_pc_q    <= 32'h0;
      end else if (out_flush) begin
         out_valid_q <= 1'b0;
      end else if (out_load) begin
         out_valid_q <= 1'b1;
         out_instr_q <= imem_instr;
         out_pc_q    <= pc;
      end
   end

   assign imem_addr    = pc[IMEM_AW-1:0];
   assign out_valid    = out_valid_q;
   assign out_instr    = out_instr_q;
   assign out_pc       = out_pc_q;
   assign out_pc_plus4 = out_pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch_fault = (state_q == StFault);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; exercises the FAULT path when FETCH_MISALIGN_TRAP_EN is defined.
module tb_fetch_unit;

   localparam int unsigned IMEM_AW = 12;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic               clk = 1'b0;
   logic               rst;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_instr;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_instr;
   logic [31:0]        out_pc;
   logic [31:0]        out_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic               fetch_fault;
`endif

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   // Address-tagged instruction memory.
   assign imem_instr = {20'hABCDE, imem_addr};

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .IMEM_AW  (IMEM_AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_fault    (fetch_fault)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst            = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step();
      step();
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_instr", out_instr, NOP);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_pc4", out_pc_plus4, 32'h4);
      chk("rst_addr", {20'b0, imem_addr}, 32'h0);

      rst = 1'b0;
      step();  // boot cycle
      chk("boot_valid", {31'b0, out_valid}, 32'h0);
      step();
      chk("s0_valid", {31'b0, out_valid}, 32'h1);
      chk("s0_pc", out_pc, 32'h0);
      chk("s0_instr", out_instr, 32'hABCDE000);
      step();
      chk("s1_pc", out_pc, 32'h4);
      step();
      chk("s2_pc", out_pc, 32'h8);
      chk("s2_instr", out_instr, 32'hABCDE008);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", out_pc, 32'h8);
         chk("stall_instr", out_instr, 32'hABCDE008);
         chk("stall_addr", {20'b0, imem_addr}, 32'hC);
         chk("stall_valid", {31'b0, out_valid}, 32'h1);
      end
      out_ready = 1'b1;
      step();
      chk("resume_pc", out_pc, 32'hC);
      step();
      chk("s10_pc", out_pc, 32'h10);

      out_ready = 1'b0;
      step();
      chk("stall10_pc", out_pc, 32'h10);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      chk("redir_valid", {31'b0, out_valid}, 32'h0);
      chk("redir_addr", {20'b0, imem_addr}, 32'h100);
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      step();
      chk("redir_out_valid", {31'b0, out_valid}, 32'h1);
      chk("redir_out_pc", out_pc, 32'h100);
      chk("redir_out_pc4", out_pc_plus4, 32'h104);
      chk("redir_out_instr", out_instr, 32'hABCDE100);

      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      chk("wrap_valid", {31'b0, out_valid}, 32'h0);
      chk("wrap_addr0", {20'b0, imem_addr}, 32'hFFC);
      redirect_valid = 1'b0;
      step();
      chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", out_pc_plus4, 32'h0);
      chk("wrap_addr1", {20'b0, imem_addr}, 32'h0);
      step();
      chk("wrap_next_pc", out_pc, 32'h0);
      chk("wrap_next_pc4", out_pc_plus4, 32'h4);

      // Handshake coinciding with redirect: register still flushed.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      chk("hs_redir_valid", {31'b0, out_valid}, 32'h0);
      redirect_valid = 1'b0;
      step();
      chk("hs_redir_pc", out_pc, 32'h40);
      chk("hs_redir_v", {31'b0, out_valid}, 32'h1);

      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
`ifdef FETCH_MISALIGN_TRAP_EN
      step();
      chk("fault_set", {31'b0, fetch_fault}, 32'h1);
      chk("fault_valid", {31'b0, out_valid}, 32'h0);
      chk("fault_addr", {20'b0, imem_addr}, 32'h102);
      redirect_valid = 1'b0;
      step();
      chk("fault_hold", {31'b0, fetch_fault}, 32'h1);
      chk("fault_hold_valid", {31'b0, out_valid}, 32'h0);
      chk("fault_hold_addr", {20'b0, imem_addr}, 32'h102);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      step();
      chk("fault_remis", {31'b0, fetch_fault}, 32'h1);
      redirect_pc = 32'h200;
      step();
      chk("fault_clear", {31'b0, fetch_fault}, 32'h0);
      chk("fault_clear_valid", {31'b0, out_valid}, 32'h0);
      redirect_valid = 1'b0;
      step();
      chk("fault_exit_pc", out_pc, 32'h200);
      chk("fault_exit_valid", {31'b0, out_valid}, 32'h1);
`else
      step();
      chk("align_addr", {20'b0, imem_addr}, 32'h100);
      redirect_valid = 1'b0;
      step();
      chk("align_pc", out_pc, 32'h100);
      chk("align_valid", {31'b0, out_valid}, 32'h1);
`endif

      // Reset overrides a simultaneous redirect and stall.
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      out_ready      = 1'b0;
      step();
      chk("rr_valid", {31'b0, out_valid}, 32'h0);
      chk("rr_instr", out_instr, NOP);
      chk("rr_pc", out_pc, 32'h0);
      chk("rr_addr", {20'b0, imem_addr}, 32'h0);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      step();
      chk("rr_boot_valid", {31'b0, out_valid}, 32'h0);
      step();
      chk("rr_run_valid", {31'b0, out_valid}, 32'h1);
      chk("rr_run_pc", out_pc, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_AW, default 12: instruction-memory byte-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  IMEM_AW  byte address to instruction memory, equal to pc[IMEM_AW-1:0].
REQ-006 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 out_valid  output  1  fetched instruction available to decode.
REQ-010 out_ready  input  1  decode accepts the current instruction.
REQ-011 out_instr  output  32  registered instruction word.
REQ-012 out_pc  output  32  PC of out_instr.
REQ-013 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.

Function
REQ-014 The FSM SHALL have states BOOT, RUN and, when FETCH_MISALIGN_TRAP_EN is defined, FAULT.
REQ-015 BOOT SHALL last exactly one cycle after reset deassertion, keep out_valid low, and go to RUN.
REQ-016 In RUN, the output register SHALL load {imem_instr, pc} and set out_valid when it is empty or out_valid && out_ready; pc then SHALL advance by 4.
REQ-017 When out_valid && !out_ready, out_instr, out_pc and pc SHALL hold (stall).
REQ-018 redirect_valid SHALL take priority over load and stall: pc <= redirect_pc, out_valid <= 0 at that edge.
REQ-019 A handshake coinciding with redirect_valid SHALL count as accepted; the output register SHALL still be flushed.
REQ-020 After a redirect in cycle N, out_valid SHALL rise at the end of cycle N+1 with out_pc = redirect target (2-cycle redirect penalty).
REQ-021 pc + 4 SHALL wrap modulo 2^32; imem_addr SHALL truncate pc, so addresses of 2^IMEM_AW and above alias.
REQ-022 Throughput SHALL be one instruction per cycle while out_ready is held high and no redirect occurs.

Reset
REQ-023 On rst: pc = RESET_PC, state = BOOT, out_valid = 0, out_instr = 32'h0000_0013 (NOP), out_pc = 0, out_pc_plus4 = 4.
REQ-024 rst asserted mid-stall or mid-redirect SHALL override all other inputs in that cycle.

Configuration
REQ-025 Macro FETCH_MISALIGN_TRAP_EN, when defined, SHALL add output fetch_fault (1 bit, reset 0).
REQ-026 With the macro, a redirect with redirect_pc[1:0] != 0 SHALL enter FAULT: out_valid = 0, fetch_fault = 1, pc frozen at the faulting target.
REQ-027 FAULT SHALL exit to RUN only on an aligned redirect, clearing fetch_fault; a misaligned redirect keeps FAULT.
REQ-028 Without the macro, redirect_pc[1:0] SHALL be forced to 2'b00 and no fetch_fault port exists.

Structure
REQ-029 Shared package riscv_pkg SHALL hold the NOP encoding constant, the default RESET_PC, and the fetch FSM state typedef.
REQ-030 Sub-module fetch_pc_reg SHALL hold the PC register plus its next-PC mux (reset, redirect, +4, hold); all else stays in fetch_unit.

Verification
REQ-031 Reset, out_ready = 1, imem returns addr-tagged words -> out_valid is 0 in BOOT, then out_pc = 0, 4, 8 on consecutive cycles.
REQ-032 out_ready low for 3 cycles at out_pc = 8 -> out_instr/out_pc stable; pc stays at 12 and streaming resumes with 12.
REQ-033 redirect_valid with redirect_pc = 0x100 while out_pc = 0x10 is stalled -> out_valid 0 next cycle, then out_pc = 0x100, out_pc_plus4 = 0x104.
REQ-034 Redirect to 0xFFFF_FFFC -> out_pc_plus4 = 0, next out_pc = 0, imem_addr = 0xFFC then 0x000.
REQ-035 Macro defined, redirect to 0x102 -> fetch_fault = 1, out_valid stays 0; redirect to 0x200 -> fault clears, out_pc = 0x200.
REQ-036 rst asserted during a redirect cycle -> pc = RESET_PC, out_instr = NOP, BOOT re-entered.
